jk_excite_ctrl: RTL
===================

# jk_excite_ctrl

Excitation controller for a bank of JK flip-flops. It accepts target state words over a valid/ready handshake and derives the J/K excitation from the bank's current Q, applying the inverse of the JK characteristic equation. It drives the bank for one cycle, then checks that Q reached the target, retrying a bounded number of times. It sits in front of any `jk_ff` register bank as the writer side: the bank stores, this block decides what to write.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the driven bank.
- `MAX_RETRY`, default 2: extra DRIVE attempts after a failed check (0 allowed).
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `tgt_valid`  input  1  target word offered.
- `tgt_ready`  output  1  block can accept a target; high only in IDLE.
- `tgt_data`  input  WIDTH  desired next Q of the bank.
- `q_in`  input  WIDTH  current Q of the external JK bank.
- `j_out`  output  WIDTH  J inputs to the bank.
- `k_out`  output  WIDTH  K inputs to the bank.
- `done`  output  1  one-cycle pulse: bank reached target.
- `mismatch`  output  1  one-cycle pulse: retries exhausted, target not reached.
- `err_cnt`  output  8  saturating count of mismatch events.

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- **IDLE**
  - `tgt_ready`=1.
  - On `tgt_valid`&`tgt_ready`: latch `tgt_data` into `tgt_r`, clear `retry_cnt`, go to DRIVE.
- **DRIVE**
  - `j_out`/`k_out` are combinational from `tgt_r` and `q_in` (excitation rule below).
  - Next state is always CHECK.
- **CHECK**
  - `j_out`=`k_out`=0. Compare `q_in` to `tgt_r`.
  - Equal: set `done`, go to IDLE.
  - Unequal and `retry_cnt`<`MAX_RETRY`: increment `retry_cnt`, go to DRIVE.
  - Unequal and `retry_cnt`=`MAX_RETRY`: set `mismatch`, increment `err_cnt` (saturates at 255), go to IDLE.
- Outside DRIVE, `j_out`=`k_out`=0, so the bank holds.
- **Excitation rule without the macro** (don't-cares resolved to 0): J = ~q & t; K = q & ~t.
- Bits already at target get J=K=0, including a target equal to the current Q.
- `tgt_valid` while not in IDLE is ignored. It is not stalled or queued; the source must hold it until `tgt_ready`.
- `retry_cnt` is wide enough for `MAX_RETRY`. Use `$clog2(MAX_RETRY+1)`, minimum 1 bit.

## Timing
- **Reset values:** state=IDLE, `tgt_ready`=1, `j_out`=0, `k_out`=0, `done`=0, `mismatch`=0, `err_cnt`=0, `tgt_r`=0, `retry_cnt`=0.
- Reset mid-operation aborts immediately (asynchronous). `j_out`/`k_out` drop to 0 without waiting for a clock. No `done`/`mismatch` is emitted for the aborted word.
- **Cycle timing for a successful first attempt:**
  - Accept at edge E0.
  - DRIVE for the cycle E0→E1; the bank captures J/K at E1.
  - CHECK for the cycle E1→E2.
  - `done` is registered and high for the cycle E2→E3.
  - `tgt_ready`=1 from E2, so the next accept is at E3 at the earliest.
  - Throughput: one word per 3 cycles.
- Each retry adds 2 cycles (DRIVE+CHECK).
- `mismatch` asserts in the cycle after the final CHECK.
- `done` and `mismatch` are registered, mutually exclusive, and last exactly one cycle.
- `q_in` is sampled combinationally in DRIVE and CHECK. The bank must update Q within one clock of its J/K.

## Configuration
- Macro: `JK_TOGGLE_EN`.
- **Defined:** bits that must change are driven with J=K=1 (toggle mode); bits at target get J=K=0.
  - Formula: J = K = q ^ t.
  - This uses the JK don't-cares as 1 and exercises the toggle path of the bank.
- **Undefined:** set/reset excitation as in Operation (J = ~q & t, K = q & ~t).
- Handshake, FSM, timing, and the check/retry logic are identical in both builds.

## Test plan
- **Set/reset from zero:** WIDTH=4, bank model at Q=0000, send `tgt_data`=1010.
  - Required in DRIVE: `j_out`=1010, `k_out`=0000 (or `k_out`=1010 with `JK_TOGGLE_EN`).
  - Required after DRIVE: bank Q=1010, `done` high exactly at E2→E3, `tgt_ready` low during DRIVE/CHECK.
- **Mixed set/reset:** Q=1100, target 1010.
  - Required without macro: `j_out`=0010, `k_out`=0100.
  - Required with macro: `j_out`=`k_out`=0110.
  - Required in both builds: `done` pulses once, Q=1010.
- **Target equals current Q:** Q=0101, target 0101 -> `j_out`=`k_out`=0000 in DRIVE, `done` 2 cycles after accept, `err_cnt` stays 0.
- **Stuck bank:** bench holds `q_in`=0000, target 0001, MAX_RETRY=2 -> three DRIVE phases each with `j_out`=0001, then one `mismatch` pulse 6 cycles after accept, `err_cnt`=1, no `done`.
- **Saturation:** 256 consecutive stuck-bank words -> `err_cnt` reaches 255 and stays 255; the block returns to IDLE after each word.
- **Reset during DRIVE:** assert `rst` mid-cycle -> `j_out`/`k_out` go to 0 before the next edge. After release: `tgt_ready`=1, `err_cnt`=0, no `done`/`mismatch` pulse, and a new word is accepted normally.

Source files
------------

// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: writer-side excitation controller for a JK flip-flop bank.
// Define JK_TOGGLE_EN to drive changing bits in toggle mode (J=K=1).
module jk_excite_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_r;
  logic [RW-1:0]    retry_cnt;
  logic [WIDTH-1:0] j_exc;
  logic [WIDTH-1:0] k_exc;

`ifdef JK_TOGGLE_EN
  assign j_exc = q_in ^ tgt_r;
  assign k_exc = q_in ^ tgt_r;
`else
  assign j_exc = ~q_in & tgt_r;
  assign k_exc = q_in & ~tgt_r;
`endif

  // Excitation reaches the bank only in DRIVE; the bank holds otherwise.
  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == DRIVE) begin
      j_out = j_exc;
      k_out = k_exc;
    end
  end

  assign tgt_ready = (state == IDLE);

  // Accept, drive, check and retry sequencing with registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tgt_r     <= '0;
      retry_cnt <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_r     <= tgt_data;
            retry_cnt <= '0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_in == tgt_r) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry_cnt < RMAX) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= DRIVE;
          end else begin
            mismatch <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
